int_simd_addsub_pipe: RTL and testbench
=======================================

Name: int_simd_addsub_pipe

Overview:
Pipelined, parametrised packed-SIMD integer add/subtract unit for the integer ALU. Lane width is selectable per operation: 8, 16, 32 bits, or one full double-width (2*W) operation. Supports pairwise and three-operand widening forms. Uses a valid/ready handshake on both sides, so it can sit between the issue stage and the writeback arbiter with back-pressure.

Parameters:
W, 32, operand width in bits; a power of two, at least 32.
STAGES, 2, pipeline depth in registers, at least 1. Input-to-output latency equals STAGES cycles when not stalled.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operation offered
in_ready  out  1  unit accepts operation this cycle
op  in  1  0 = subtract, 1 = add
form  in  1  0 = pairwise, 1 = three-operand widening
precision  in  2  0 = 8-bit lanes, 1 = 16-bit, 2 = 32-bit, 3 = double-width
sgn  in  1  signed saturation select; used only with the optional feature
A, B, C, D  in  W each  packed operands
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
Y1, Y2  out  W each  packed results
sat_hit  out  1  at least one lane saturated; 0 without the optional feature

Behaviour:
- Reset: all stage-valid bits = 0; out_valid = 0; Y1 = Y2 = 0; sat_hit = 0. A reset mid-flight discards every in-flight operation.
- Lane width: n = 8 << precision for precision 0–2; there are W/n lanes. Lane i covers bits [(i+1)n-1 : i*n].
- Pairwise form (form = 0), per lane, modulo 2^n:
  - Y1 = A op C.
  - Y2 = B op D.
- Widening form (form = 1), per lane:
  - Operands are zero-extended to 2n bits.
  - r = A op B op C, where subtract gives A - B - C and add gives A + B + C, modulo 2^2n.
  - Y1 lane = r[2n-1:n]; Y2 lane = r[n-1:0].
- Precision 3: form is ignored; {Y1,Y2} = {A,B} op {C,D}, modulo 2^(2W).
- Lane isolation: a carry or borrow never crosses a lane boundary.
- Compute placement: arithmetic is done in stage 0. Later stages only carry data.
- Elastic pipeline:
  - Stage k loads when stage k+1 is empty or advancing; the last stage advances when out_ready = 1.
  - in_ready = !v[0] || stage 0 advancing. This is combinational from out_ready through the chain.
  - A transfer happens on a cycle with in_valid && in_ready.
- Output stability: out_valid together with Y1, Y2 and sat_hit reflect the last stage. They stay stable while out_valid && !out_ready.
- Throughput: one operation per cycle with no bubbles when out_ready is held at 1.
- Full pipeline with out_ready = 0: in_ready = 0. The first cycle out_ready rises, one result drains and one new operation is accepted in the same cycle.
- Ordering: results leave strictly in issue order.

Optional Feature:
Macro: INT_SIMD_ADDSUB_SAT_EN.
- With the macro, the pairwise form (form = 0, precision 0–2) saturates:
  - sgn = 1: signed saturation to [-2^(n-1), 2^(n-1)-1].
  - sgn = 0: unsigned saturation to [0, 2^n-1].
  - sat_hit = OR over all lanes of both results that saturated, pipelined alongside the data.
- Widening form and precision 3 never saturate.
- Without the macro, results wrap, sgn is ignored and sat_hit is tied to 0.

Decomposition:
- Shared package int_alu_pkg holds:
  - precision encodings PREC_8, PREC_16, PREC_32, PREC_WIDE;
  - op encodings OP_SUB, OP_ADD;
  - form encodings FORM_PAIR, FORM_WIDE.
- Sub-module int_simd_lane_addsub(n): one lane's pairwise and widening compute plus saturation. It is generated W/n times per precision, and the top level muxes by precision.
- The elastic stage register is written inline in a generate loop over STAGES.

Test Plan:
1. Byte pairwise subtract, W = 32. prec = 0, op = 0, form = 0, A = 0x01020304, C = 0x02020202, B = 0x10, D = 0x11 -> Y1 = 0xFF000102, Y2 = 0x000000FF, appearing 2 cycles after acceptance.
2. Lane isolation. prec = 1, op = 1, A = 0x0000FFFF, C = 0x00000001 -> Y1 = 0x00000000; no carry into the upper lane.
3. Widening subtract, W = 32. prec = 2, form = 1, op = 0, A = 5, B = 7, C = 0 -> Y1 = 0xFFFFFFFF, Y2 = 0xFFFFFFFE.
4. Double-width subtract. prec = 3, op = 0, {A,B} = {0x1, 0x0}, {C,D} = {0x0, 0x1} -> Y1 = 0x00000000, Y2 = 0xFFFFFFFF.
5. Back-pressure. Issue 4 back-to-back ops while out_ready = 0:
   - in_ready falls after STAGES accepts.
   - Outputs stay stable while stalled.
   - Releasing out_ready yields all results in order, one per cycle.
   - Asserting rst mid-stall clears out_valid on the next cycle.
6. With INT_SIMD_ADDSUB_SAT_EN: prec = 0, sgn = 1, op = 0, A = 0x80, C = 0x01 -> Y1 lane 0 = 0x80, sat_hit = 1. Same stimulus with sgn = 0, A = 0x00, C = 0x01 -> lane 0 = 0x00, sat_hit = 1. Without the macro the same stimulus gives 0x7F and 0xFF with sat_hit = 0.

Source files
------------

// File: rtl/int_alu_pkg.sv
// ---------------------------------------------------------------------------
// int_alu_pkg
// Shared encodings for the integer ALU datapath blocks.
//   prec_e : lane-width select (8/16/32-bit lanes, or one double-width op)
//   op_e   : subtract / add
//   form_e : pairwise / three-operand widening
// ---------------------------------------------------------------------------
package int_alu_pkg;

    typedef enum logic [1:0] {
        PREC_8    = 2'd0,
        PREC_16   = 2'd1,
        PREC_32   = 2'd2,
        PREC_WIDE = 2'd3
    } prec_e;

    typedef enum logic {
        OP_SUB = 1'b0,
        OP_ADD = 1'b1
    } op_e;

    typedef enum logic {
        FORM_PAIR = 1'b0,
        FORM_WIDE = 1'b1
    } form_e;

    // Number of lane-based precisions (PREC_8..PREC_32).
    localparam int NUM_LANE_PREC = 3;

    // Lane width in bits for a lane-based precision code.
    function automatic int lane_width(input int prec);
        return 8 << prec;
    endfunction

endpackage

// File: rtl/int_simd_lane_addsub.sv
// ---------------------------------------------------------------------------
// int_simd_lane_addsub
// One N-bit SIMD lane: pairwise add/sub (y1 = a op c, y2 = b op d) and the
// three-operand widening form (r = a op b op c over 2N bits, y1 = high half,
// y2 = low half).
// Optional feature macro: INT_SIMD_ADDSUB_SAT_EN -- pairwise results saturate
// (signed when sgn = 1, unsigned otherwise) and sat flags a clipped result.
// Without the macro results wrap, sgn is ignored and sat = 0.
// Ports:
//   a, b, c, d : lane operands (N bits)
//   op         : 0 = subtract, 1 = add
//   form       : 0 = pairwise, 1 = widening
//   sgn        : signed saturation select
//   y1, y2     : lane results
//   sat        : either pairwise result saturated
// ---------------------------------------------------------------------------
module int_simd_lane_addsub
    import int_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic         op,
    input  logic         form,
    input  logic         sgn,
    output logic [N-1:0] y1,
    output logic [N-1:0] y2,
    output logic         sat
);

    // Widening form: zero-extended operands, arithmetic modulo 2^(2N).
    logic [2*N-1:0] ax, bx, cx, wide_r;
    assign ax = {{N{1'b0}}, a};
    assign bx = {{N{1'b0}}, b};
    assign cx = {{N{1'b0}}, c};
    assign wide_r = (op == OP_ADD) ? (ax + bx + cx) : (ax - bx - cx);

    logic [N-1:0] p1, p2;
    logic         h1, h2;

`ifdef INT_SIMD_ADDSUB_SAT_EN
    // Returns {hit, result}. One extra bit of headroom exposes the overflow:
    // signed overflow when the two top bits disagree, unsigned when the
    // carry/borrow bit is set.
    function automatic logic [N:0] sat_addsub(input logic [N-1:0] x,
                                              input logic [N-1:0] y,
                                              input logic         add,
                                              input logic         s);
        logic [N:0]   r;
        logic [N-1:0] res;
        logic         hit;
        if (s) begin
            r   = add ? ({x[N-1], x} + {y[N-1], y}) : ({x[N-1], x} - {y[N-1], y});
            hit = r[N] ^ r[N-1];
            if (hit)
                res = r[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            else
                res = r[N-1:0];
        end else begin
            r   = add ? ({1'b0, x} + {1'b0, y}) : ({1'b0, x} - {1'b0, y});
            hit = r[N];
            if (hit)
                res = add ? {N{1'b1}} : {N{1'b0}};
            else
                res = r[N-1:0];
        end
        return {hit, res};
    endfunction

    assign {h1, p1} = sat_addsub(a, c, op == OP_ADD, sgn);
    assign {h2, p2} = sat_addsub(b, d, op == OP_ADD, sgn);
`else
    logic sgn_unused;
    assign sgn_unused = sgn;
    assign p1 = (op == OP_ADD) ? (a + c) : (a - c);
    assign p2 = (op == OP_ADD) ? (b + d) : (b - d);
    assign h1 = 1'b0;
    assign h2 = 1'b0;
`endif

    assign y1  = (form == FORM_WIDE) ? wide_r[2*N-1:N] : p1;
    assign y2  = (form == FORM_WIDE) ? wide_r[N-1:0]   : p2;
    // The widening form never saturates.
    assign sat = (form == FORM_PAIR) && (h1 || h2);

endmodule

// File: rtl/int_simd_addsub_pipe.sv
// ---------------------------------------------------------------------------
// int_simd_addsub_pipe
// Pipelined packed-SIMD integer add/subtract with valid/ready on both sides.
// All arithmetic happens ahead of stage 0; the STAGES elastic registers only
// carry results. Latency is STAGES cycles when not stalled, full throughput
// when out_ready stays high.
// Optional feature macro: INT_SIMD_ADDSUB_SAT_EN (pairwise saturation and
// sat_hit reporting; without it results wrap and sat_hit = 0).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_ready : input handshake (in_ready combinational from out_ready)
//   op                 : 0 = subtract, 1 = add
//   form               : 0 = pairwise, 1 = three-operand widening
//   precision          : 0/1/2 = 8/16/32-bit lanes, 3 = one 2W-bit op
//   sgn                : signed saturation select (saturation builds only)
//   A, B, C, D         : packed operands
//   out_valid, out_ready : output handshake
//   Y1, Y2             : packed results
//   sat_hit            : some lane saturated
// ---------------------------------------------------------------------------
module int_simd_addsub_pipe
    import int_alu_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic         form,
    input  logic [1:0]   precision,
    input  logic         sgn,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    input  logic [W-1:0] D,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic         sat_hit
);

    // -----------------------------------------------------------------------
    // Compute: every lane precision is evaluated in parallel, then selected.
    // -----------------------------------------------------------------------
    logic [NUM_LANE_PREC-1:0][W-1:0] lane_y1;
    logic [NUM_LANE_PREC-1:0][W-1:0] lane_y2;
    logic [NUM_LANE_PREC-1:0]        lane_sat;

    genvar gp, gi;
    generate
        for (gp = 0; gp < NUM_LANE_PREC; gp++) begin : g_prec
            localparam int N = lane_width(gp);
            localparam int L = W / N;
            logic [L-1:0] sat_l;
            for (gi = 0; gi < L; gi++) begin : g_lane
                int_simd_lane_addsub #(.N(N)) u_lane (
                    .a    (A[gi*N +: N]),
                    .b    (B[gi*N +: N]),
                    .c    (C[gi*N +: N]),
                    .d    (D[gi*N +: N]),
                    .op   (op),
                    .form (form),
                    .sgn  (sgn),
                    .y1   (lane_y1[gp][gi*N +: N]),
                    .y2   (lane_y2[gp][gi*N +: N]),
                    .sat  (sat_l[gi])
                );
            end
            assign lane_sat[gp] = |sat_l;
        end
    endgenerate

    // Double-width: {A,B} op {C,D}, form ignored, never saturates.
    logic [2*W-1:0] wide_res;
    assign wide_res = (op == OP_ADD) ? ({A, B} + {C, D}) : ({A, B} - {C, D});

    logic [W-1:0] y1_calc, y2_calc;
    logic         sat_calc;

    always_comb begin
        y1_calc  = lane_y1[0];
        y2_calc  = lane_y2[0];
        sat_calc = lane_sat[0];
        case (prec_e'(precision))
            PREC_16: begin
                y1_calc  = lane_y1[1];
                y2_calc  = lane_y2[1];
                sat_calc = lane_sat[1];
            end
            PREC_32: begin
                y1_calc  = lane_y1[2];
                y2_calc  = lane_y2[2];
                sat_calc = lane_sat[2];
            end
            PREC_WIDE: begin
                y1_calc  = wide_res[2*W-1:W];
                y2_calc  = wide_res[W-1:0];
                sat_calc = 1'b0;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Elastic pipeline. Stage k may load when it is empty or its content is
    // leaving; the chain runs back from out_ready, so in_ready is
    // combinational on out_ready.
    // -----------------------------------------------------------------------
    logic [STAGES-1:0]        v_reg;
    logic [STAGES-1:0][W-1:0] y1_reg;
    logic [STAGES-1:0][W-1:0] y2_reg;
    logic [STAGES-1:0]        sat_reg;
    logic [STAGES-1:0]        load_en;
    logic                     downstream_free;

    always_comb begin
        downstream_free = out_ready;
        load_en         = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load_en[k]      = !v_reg[k] || downstream_free;
            downstream_free = load_en[k];
        end
    end

    assign in_ready = load_en[0];

    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic         v_in;
            logic [W-1:0] y1_in, y2_in;
            logic         sat_in;

            if (gi == 0) begin : g_head
                assign v_in   = in_valid;
                assign y1_in  = y1_calc;
                assign y2_in  = y2_calc;
                assign sat_in = sat_calc;
            end else begin : g_body
                assign v_in   = v_reg[gi-1];
                assign y1_in  = y1_reg[gi-1];
                assign y2_in  = y2_reg[gi-1];
                assign sat_in = sat_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_reg[gi]   <= 1'b0;
                    y1_reg[gi]  <= '0;
                    y2_reg[gi]  <= '0;
                    sat_reg[gi] <= 1'b0;
                end else if (load_en[gi]) begin
                    v_reg[gi] <= v_in;
                    // Payload only moves with a valid token, so an emptied
                    // stage keeps its last data rather than toggling.
                    if (v_in) begin
                        y1_reg[gi]  <= y1_in;
                        y2_reg[gi]  <= y2_in;
                        sat_reg[gi] <= sat_in;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = v_reg[STAGES-1];
    assign Y1        = y1_reg[STAGES-1];
    assign Y2        = y2_reg[STAGES-1];
    assign sat_hit   = sat_reg[STAGES-1];

endmodule

// File: tb/tb_int_simd_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_int_simd_addsub_pipe
// Self-checking bench: directed vectors, back-pressure, back-to-back and
// randomized traffic compared against a lane-arithmetic reference model.
// Honours INT_SIMD_ADDSUB_SAT_EN when defined for the build.
// ---------------------------------------------------------------------------
module tb_int_simd_addsub_pipe;

    localparam int W      = 32;
    localparam int STAGES = 2;

`ifdef INT_SIMD_ADDSUB_SAT_EN
    localparam logic SAT_ON = 1'b1;
`else
    localparam logic SAT_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic         op, form, sgn, sat_hit;
    logic [1:0]   precision;
    logic [W-1:0] A, B, C, D, Y1, Y2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         add;
        logic         wide_form;
        logic [1:0]   prec;
        logic         s;
        logic [W-1:0] a, b, c, d;
    } op_t;

    typedef struct {
        logic [W-1:0] y1, y2;
        logic         sat;
    } res_t;

    res_t sb[$];

    always #5 clk = ~clk;

    int_simd_addsub_pipe #(.W(W), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .form      (form),
        .precision (precision),
        .sgn       (sgn),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y1        (Y1),
        .Y2        (Y2),
        .sat_hit   (sat_hit)
    );

    // ---------------- reference model ----------------
    function automatic longint pair_lane(input int n, input logic add, input logic s,
                                         input longint x, input longint y, output logic hit);
        longint m, r;
        m   = (longint'(1) << n) - 1;
        hit = 1'b0;
`ifdef INT_SIMD_ADDSUB_SAT_EN
        begin
            longint lo, hi, sx, sy;
            sx = x; sy = y; lo = 0; hi = m;
            if (s) begin
                hi = (longint'(1) << (n - 1)) - 1;
                lo = -hi - 1;
                if (x > hi) sx = x - m - 1;
                if (y > hi) sy = y - m - 1;
            end
            r = add ? sx + sy : sx - sy;
            if (r > hi) begin r = hi; hit = 1'b1; end
            else if (r < lo) begin r = lo; hit = 1'b1; end
        end
`else
        r   = add ? x + y : x - y;
        hit = s & 1'b0;
`endif
        return r & m;
    endfunction

    function automatic res_t model(input op_t o);
        res_t           r;
        logic [2*W-1:0] full;
        logic [63:0]    acc, v1, v2;
        longint         m;
        int             n;
        logic           h1, h2;
        r.y1 = '0; r.y2 = '0; r.sat = 1'b0;
        if (o.prec == 2'd3) begin
            full = o.add ? {o.a, o.b} + {o.c, o.d} : {o.a, o.b} - {o.c, o.d};
            r.y1 = full[2*W-1:W];
            r.y2 = full[W-1:0];
            return r;
        end
        n = 8 << o.prec;
        m = (longint'(1) << n) - 1;
        for (int i = 0; i < W / n; i++) begin
            longint xa, xb, xc, xd;
            xa = longint'(64'(o.a) >> (i * n)) & m;
            xb = longint'(64'(o.b) >> (i * n)) & m;
            xc = longint'(64'(o.c) >> (i * n)) & m;
            xd = longint'(64'(o.d) >> (i * n)) & m;
            if (!o.wide_form) begin
                v1 = pair_lane(n, o.add, o.s, xa, xc, h1);
                v2 = pair_lane(n, o.add, o.s, xb, xd, h2);
                r.sat = r.sat | h1 | h2;
            end else begin
                acc = o.add ? xa + xb + xc : xa - xb - xc;
                if (2 * n < 64) acc = acc & ((64'd1 << (2 * n)) - 1);
                v1 = (acc >> n) & m;
                v2 = acc & m;
            end
            r.y1 = r.y1 | W'(v1 << (i * n));
            r.y2 = r.y2 | W'(v2 << (i * n));
        end
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 4))
            0:       return '1;
            1:       return {(W/8){8'h80}};
            2:       return {(W/8){8'h7F}};
            3:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic op_t random_op();
        op_t o;
        o.add       = 1'($urandom_range(0, 1));
        o.wide_form = 1'($urandom_range(0, 1));
        o.prec      = 2'($urandom_range(0, 3));
        o.s         = 1'($urandom_range(0, 1));
        o.a = rnd_operand(); o.b = rnd_operand();
        o.c = rnd_operand(); o.d = rnd_operand();
        return o;
    endfunction

    task automatic apply_op(input op_t o);
        op = o.add; form = o.wide_form; precision = o.prec; sgn = o.s;
        A = o.a; B = o.b; C = o.c; D = o.d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        apply_op('{1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0, '0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, Y1, Y2, sat_hit} !== {1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0})
            $display("FAIL reset_state got v=%b Y1=%h Y2=%h sat=%b want 0/0/0/0",
                     out_valid, Y1, Y2, sat_hit);
        if ({out_valid, Y1, Y2, sat_hit} !== {1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0}) errors++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        op_t   vo[6];
        res_t  vr[6];
        string nm[6];
        int    lat;
        vo[0] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h01020304, 32'h10, 32'h02020202, 32'h11};
        vr[0] = '{32'hFF000102, 32'h000000FF, 1'b0};  nm[0] = "byte_sub";
        vo[1] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0000FFFF, 32'h0, 32'h1, 32'h0};
        vr[1] = '{32'h00000000, 32'h00000000, 1'b0};  nm[1] = "lane_isolation";
        vo[2] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0};
        vr[2] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};  nm[2] = "widen_sub";
        vo[3] = '{1'b0, 1'b0, 2'd3, 1'b0, 32'h1, 32'h0, 32'h0, 32'h1};
        vr[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b0};  nm[3] = "double_sub";
        vo[4] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h80, 32'h0, 32'h01, 32'h0};
        vr[4] = '{SAT_ON ? 32'h80 : 32'h7F, 32'h0, SAT_ON};  nm[4] = "signed_sat";
        vo[5] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h00, 32'h0, 32'h01, 32'h0};
        vr[5] = '{SAT_ON ? 32'h00 : 32'hFF, 32'h0, SAT_ON};  nm[5] = "unsigned_sat";

        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            apply_op(vo[t]);
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_in_ready got %b want 1", nm[t], in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            for (int cyc = 1; cyc <= 8 && lat == 0; cyc++) begin
                @(negedge clk);
                if (out_valid) lat = cyc;
                else begin @(posedge clk); #1; end
            end
            checks++;
            if (lat != STAGES) begin
                errors++;
                $display("FAIL %s_latency got %0d want %0d", nm[t], lat, STAGES);
            end
            checks++;
            if ({Y1, Y2, sat_hit} !== {vr[t].y1, vr[t].y2, vr[t].sat}) begin
                errors++;
                $display("FAIL %s got Y1=%h Y2=%h sat=%b want Y1=%h Y2=%h sat=%b",
                         nm[t], Y1, Y2, sat_hit, vr[t].y1, vr[t].y2, vr[t].sat);
            end
            $display("vec %s Y1=%h Y2=%h sat=%b latency=%0d", nm[t], Y1, Y2, sat_hit, lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        op_t  ops[4];
        res_t held, exp_r;
        int   accepts = 0;
        logic seen = 1'b0;
        logic exp_rdy;
        for (int i = 0; i < 4; i++) ops[i] = random_op();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < STAGES + 4; cyc++) begin
            in_valid = (accepts < 4);
            if (accepts < 4) apply_op(ops[accepts]);
            @(negedge clk);
            exp_rdy = (accepts < STAGES);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL bp_in_ready cyc=%0d got %b want %b", cyc, in_ready, exp_rdy);
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(ops[accepts]));
                accepts++;
            end
            if (out_valid) begin
                if (!seen) begin
                    held = '{Y1, Y2, sat_hit};
                    seen = 1'b1;
                end else begin
                    checks++;
                    if ({Y1, Y2, sat_hit} !== {held.y1, held.y2, held.sat}) begin
                        errors++;
                        $display("FAIL bp_stable got %h/%h/%b want %h/%h/%b",
                                 Y1, Y2, sat_hit, held.y1, held.y2, held.sat);
                    end
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (accepts != STAGES || !seen) begin
            errors++;
            $display("FAIL bp_fill got accepts=%0d out_valid_seen=%b want %0d/1", accepts, seen, STAGES);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = (accepts < 4);
            if (accepts < 4) apply_op(ops[accepts]);
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_release_ready got %b want 1", in_ready);
                end
            end
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("FAIL bp_drain_gap cyc=%0d got out_valid=%b want 1", cyc, out_valid);
            end else begin
                exp_r = sb.pop_front();
                checks++;
                if ({Y1, Y2, sat_hit} !== {exp_r.y1, exp_r.y2, exp_r.sat}) begin
                    errors++;
                    $display("FAIL bp_drain_data got %h/%h/%b want %h/%h/%b",
                             Y1, Y2, sat_hit, exp_r.y1, exp_r.y2, exp_r.sat);
                end
                $display("bp drain %0d Y1=%h Y2=%h sat=%b", cyc, Y1, Y2, sat_hit);
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(ops[accepts]));
                accepts++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (accepts != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_all_issued got accepts=%0d pending=%0d want 4/0", accepts, sb.size());
        end

        // Fill with back-pressure, then reset mid-stall.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (STAGES + 1) begin
            apply_op(random_op());
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stalled_full got out_valid=%b want 1", out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, Y1, Y2, sat_hit, in_ready} !== {1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bp_midstall_reset got v=%b Y1=%h Y2=%h sat=%b rdy=%b want 0/0/0/0/1",
                     out_valid, Y1, Y2, sat_hit, in_ready);
        end
        $display("bp midstall reset out_valid=%b", out_valid);
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        int   sent = 0, got = 0;
        logic started = 1'b0;
        res_t exp_r;
        op_t  cur;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < N + STAGES + 4 && got < N; cyc++) begin
            cur = random_op();
            in_valid = (sent < N);
            apply_op(cur);
            @(negedge clk);
            if (out_valid) begin
                started = 1'b1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got out_valid=1 want no pending result");
                end else begin
                    exp_r = sb.pop_front();
                    if ({Y1, Y2, sat_hit} !== {exp_r.y1, exp_r.y2, exp_r.sat}) begin
                        errors++;
                        $display("FAIL b2b_data got %h/%h/%b want %h/%h/%b",
                                 Y1, Y2, sat_hit, exp_r.y1, exp_r.y2, exp_r.sat);
                    end
                end
                got++;
            end else if (started && got < N) begin
                checks++;
                errors++;
                $display("FAIL b2b_bubble got out_valid=0 want 1 at result %0d", got);
            end
            if (in_valid) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready got %b want 1", in_ready);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(cur));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (got != N) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", got, N);
        end
        $display("b2b issued=%0d retired=%0d", sent, got);
    endtask

    task automatic test_random();
        res_t exp_r, prev;
        logic prev_stall = 1'b0;
        op_t  cur;
        int   retired = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cur = random_op();
            apply_op(cur);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || {Y1, Y2, sat_hit} !== {prev.y1, prev.y2, prev.sat}) begin
                    errors++;
                    $display("FAIL rnd_stable got v=%b %h/%h/%b want 1 %h/%h/%b",
                             out_valid, Y1, Y2, sat_hit, prev.y1, prev.y2, prev.sat);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra got unexpected result %h/%h", Y1, Y2);
                end else begin
                    exp_r = sb.pop_front();
                    if ({Y1, Y2, sat_hit} !== {exp_r.y1, exp_r.y2, exp_r.sat}) begin
                        errors++;
                        $display("FAIL rnd_data got %h/%h/%b want %h/%h/%b",
                                 Y1, Y2, sat_hit, exp_r.y1, exp_r.y2, exp_r.sat);
                    end
                end
                retired++;
            end
            if (in_valid && in_ready) sb.push_back(model(cur));
            prev_stall = out_valid && !out_ready;
            prev       = '{Y1, Y2, sat_hit};
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < STAGES + 4 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                exp_r = sb.pop_front();
                checks++;
                if ({Y1, Y2, sat_hit} !== {exp_r.y1, exp_r.y2, exp_r.sat}) begin
                    errors++;
                    $display("FAIL rnd_drain got %h/%h/%b want %h/%h/%b",
                             Y1, Y2, sat_hit, exp_r.y1, exp_r.y2, exp_r.sat);
                end
                retired++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rnd_leftover got %0d pending want 0", sb.size());
        end
        $display("random retired=%0d", retired);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
